// File: rtl/mvm_seq_ctrl.sv
// Sequencer for the matrix-vector multiply datapath: streams A and x into memory,
// then walks the A/X reads for each row and hands y[row] out over valid/ready.
module mvm_seq_ctrl #(
    parameter int  M       = 3,
    parameter int  N       = 3,
    parameter int  MEM_LAT = 1,
    parameter int  AW      = (M * N > 1) ? $clog2(M * N) : 1,
    parameter int  XW      = (N > 1) ? $clog2(N) : 1,
    localparam int RW      = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          m_ready,
    output logic          m_valid,
    output logic [AW-1:0] addr_a,
    output logic          wr_en_a,
    output logic [XW-1:0] addr_x,
    output logic          wr_en_x,
    output logic          mac_en,
    output logic          mac_clear,
    output logic [RW-1:0] out_row,
    output logic          done
);

    localparam int DW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [AW-1:0] LAST_A     = AW'(M * N - 1);
    localparam logic [AW-1:0] ROW_STEP   = AW'(N);
    localparam logic [XW-1:0] LAST_K     = XW'(N - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(M - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_X,
        ISSUE,
        DRAIN,
        OUT
    } state_t;

    state_t             state_q;
    logic [AW-1:0]      loadCnt_q;
    logic [AW-1:0]      rowBase_q;
    logic [XW-1:0]      k_q;
    logic [RW-1:0]      row_q;
    logic [DW-1:0]      drainCnt_q;
    logic [MEM_LAT-1:0] pipeEn_q;
    logic [MEM_LAT-1:0] pipeFirst_q;

    logic hs;
    logic outHs;

    assign s_ready   = (state_q == LOAD_A) || (state_q == LOAD_X);
    assign hs        = s_valid & s_ready;
    assign wr_en_a   = hs && (state_q == LOAD_A);
    assign wr_en_x   = hs && (state_q == LOAD_X);
    assign addr_a    = (state_q == ISSUE) ? rowBase_q + AW'(k_q) : loadCnt_q;
    assign addr_x    = k_q;
    assign m_valid   = (state_q == OUT);
    assign out_row   = row_q;
    assign outHs     = m_valid & m_ready;
    assign done      = outHs && (row_q == LAST_ROW);
    assign mac_en    = pipeEn_q[MEM_LAT-1];
    assign mac_clear = pipeFirst_q[MEM_LAT-1];

    // k_q doubles as the X load index and the per-row read index; it is zero
    // whenever neither is in progress, so addr_x needs no extra mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD_A;
            loadCnt_q   <= '0;
            rowBase_q   <= '0;
            k_q         <= '0;
            row_q       <= '0;
            drainCnt_q  <= '0;
            pipeEn_q    <= '0;
            pipeFirst_q <= '0;
        end else begin
            // Enable pipe mirrors memory read latency so mac_en meets the data.
            pipeEn_q[0]    <= (state_q == ISSUE);
            pipeFirst_q[0] <= (state_q == ISSUE) && (k_q == '0);
            for (int i = 1; i < MEM_LAT; i++) begin
                pipeEn_q[i]    <= pipeEn_q[i-1];
                pipeFirst_q[i] <= pipeFirst_q[i-1];
            end

            case (state_q)
                LOAD_A: begin
                    if (hs) begin
                        if (loadCnt_q == LAST_A) begin
                            loadCnt_q <= '0;
                            state_q   <= LOAD_X;
                        end else begin
                            loadCnt_q <= loadCnt_q + 1'b1;
                        end
                    end
                end
                LOAD_X: begin
                    if (hs) begin
                        if (k_q == LAST_K) begin
                            k_q       <= '0;
                            row_q     <= '0;
                            rowBase_q <= '0;
                            state_q   <= ISSUE;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (k_q == LAST_K) begin
                        k_q        <= '0;
                        drainCnt_q <= '0;
                        state_q    <= DRAIN;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drainCnt_q == LAST_DRAIN) begin
                        state_q <= OUT;
                    end else begin
                        drainCnt_q <= drainCnt_q + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        if (row_q == LAST_ROW) begin
                            row_q     <= '0;
                            rowBase_q <= '0;
                            state_q   <= LOAD_A;
                        end else begin
                            row_q     <= row_q + 1'b1;
                            rowBase_q <= rowBase_q + ROW_STEP;
                            state_q   <= ISSUE;
                        end
                    end
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Scoreboard bench: two controllers (MEM_LAT=1 and MEM_LAT=2) share the load stream,
// each wired to its own 8-bit memories and MAC; a monitor pops expected y per handshake.
module tb_mvm_seq_ctrl;

    localparam int M = 3;
    localparam int N = 3;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic sValid = 1'b0;
    logic mReady = 1'b1;
    logic signed [7:0] sData = '0;

    logic [1:0]       sReady, mValid, wrEnA, wrEnX, macEn, macClear, done;
    logic [1:0][3:0]  addrA;
    logic [1:0][1:0]  addrX;
    logic [1:0][1:0]  outRow;
    logic [1:0][15:0] yOut;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int doneCnt[2];
    int wrIdx[2];
    int rowStart[2];
    int prevRow[2];
    int prevY[2];
    bit expFirstEn[2];
    bit mvSeen[2];
    bit prevStall[2];
    bit expectReady[2];

    typedef struct {
        int row;
        int y;
    } exp_t;
    exp_t expQ0[$];
    exp_t expQ1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    function automatic logic signed [15:0] mul8(input logic signed [7:0] a, input logic signed [7:0] b);
        logic signed [15:0] ae;
        logic signed [15:0] be;
        ae = a;
        be = b;
        return ae * be;
    endfunction

    // Each controller gets private memories with a read pipe matching its MEM_LAT.
    for (genvar g = 0; g < 2; g++) begin : gDut
        logic signed [7:0]  memA [16];
        logic signed [7:0]  memX [4];
        logic signed [7:0]  rdA  [2];
        logic signed [7:0]  rdX  [2];
        logic signed [15:0] acc;

        mvm_seq_ctrl #(.M(M), .N(N), .MEM_LAT(g + 1)) dut (
            .clk      (clk),
            .reset    (reset),
            .s_valid  (sValid),
            .s_ready  (sReady[g]),
            .m_ready  (mReady),
            .m_valid  (mValid[g]),
            .addr_a   (addrA[g]),
            .wr_en_a  (wrEnA[g]),
            .addr_x   (addrX[g]),
            .wr_en_x  (wrEnX[g]),
            .mac_en   (macEn[g]),
            .mac_clear(macClear[g]),
            .out_row  (outRow[g]),
            .done     (done[g])
        );

        always @(posedge clk) begin
            if (wrEnA[g]) memA[addrA[g]] <= sData;
            if (wrEnX[g]) memX[addrX[g]] <= sData;
            rdA[0] <= memA[addrA[g]];
            rdA[1] <= rdA[0];
            rdX[0] <= memX[addrX[g]];
            rdX[1] <= rdX[0];
            if (macEn[g]) acc <= macClear[g] ? mul8(rdA[g], rdX[g]) : acc + mul8(rdA[g], rdX[g]);
        end

        assign yOut[g] = acc;
    end

    function automatic void checkOutput(input string name, input int g, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %0d, expected %0d", name, g, actual, expected);
        end
    endfunction

    function automatic void pushExp(input int g, input int row, input int y);
        exp_t e;
        e.row = row;
        e.y   = y;
        if (g == 0) expQ0.push_back(e);
        else        expQ1.push_back(e);
    endfunction

    // Monitor: scoreboard pops, write ordering, enable latency and stall stability.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            exp_t e;
            int   qs;
            if (reset) begin
                if (g == 0) expQ0.delete();
                else        expQ1.delete();
                wrIdx[g]       = 0;
                expFirstEn[g]  = 0;
                mvSeen[g]      = 0;
                prevStall[g]   = 0;
                expectReady[g] = 0;
            end else begin
                if (expectReady[g]) begin
                    checkOutput("s_ready_after_done", g, int'(sReady[g]), 1);
                    expectReady[g] = 0;
                end
                if (wrEnA[g]) begin
                    checkOutput("wr_addr_a", g, int'(addrA[g]), wrIdx[g]);
                    wrIdx[g]++;
                end
                if (wrEnX[g]) begin
                    checkOutput("wr_addr_x", g, int'(addrX[g]), wrIdx[g] - M * N);
                    if (wrIdx[g] == M * N + N - 1) begin
                        rowStart[g]   = cycle + 1;
                        expFirstEn[g] = 1;
                        mvSeen[g]     = 0;
                    end
                    wrIdx[g]++;
                end
                checkOutput("clear_needs_en", g, int'(macClear[g] && !macEn[g]), 0);
                checkOutput("done_only_on_hs", g, int'(done[g] && !(mValid[g] && mReady)), 0);
                if (done[g]) doneCnt[g]++;
                if (macEn[g] && expFirstEn[g]) begin
                    checkOutput("mac_en_latency", g, cycle - rowStart[g], g + 1);
                    checkOutput("first_mac_clear", g, int'(macClear[g]), 1);
                    expFirstEn[g] = 0;
                end
                if (mValid[g]) begin
                    checkOutput("no_mac_in_out", g, int'(macEn[g]), 0);
                    if (!mvSeen[g]) begin
                        checkOutput("row_latency", g, cycle - rowStart[g], N + g + 1);
                        mvSeen[g] = 1;
                    end
                end
                if (mValid[g] && !mReady) begin
                    if (prevStall[g]) begin
                        checkOutput("stall_row", g, int'(outRow[g]), prevRow[g]);
                        checkOutput("stall_y", g, int'($signed(yOut[g])), prevY[g]);
                    end
                    prevStall[g] = 1;
                    prevRow[g]   = int'(outRow[g]);
                    prevY[g]     = int'($signed(yOut[g]));
                end else begin
                    prevStall[g] = 0;
                end
                if (mValid[g] && mReady) begin
                    qs = (g == 0) ? expQ0.size() : expQ1.size();
                    if (qs == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_output dut%0d: got row %0d y %0d, expected none",
                                 g, outRow[g], $signed(yOut[g]));
                    end else begin
                        e = (g == 0) ? expQ0.pop_front() : expQ1.pop_front();
                        checkOutput("out_row", g, int'(outRow[g]), e.row);
                        checkOutput("y", g, int'($signed(yOut[g])), e.y);
                        if (e.row == M - 1) begin
                            checkOutput("done_pulse", g, int'(done[g]), 1);
                            checkOutput("write_count", g, wrIdx[g], M * N + N);
                            expectReady[g] = 1;
                            wrIdx[g]       = 0;
                        end else begin
                            checkOutput("done_pulse", g, int'(done[g]), 0);
                            rowStart[g]   = cycle + 1;
                            expFirstEn[g] = 1;
                            mvSeen[g]     = 0;
                        end
                    end
                end
            end
        end
    end

    // Loads one A+x stream in lockstep into both controllers; gapPct inserts idle cycles.
    task automatic applyStimulus(input logic signed [7:0] w[12], input int gapPct,
                                 input int y0, input int y1, input int y2);
        int guard;
        for (int g = 0; g < 2; g++) begin
            pushExp(g, 0, y0);
            pushExp(g, 1, y1);
            pushExp(g, 2, y2);
        end
        for (int i = 0; i < M * N + N; i++) begin
            sValid = 1'b0;
            while (gapPct > 0 && $urandom_range(99) < gapPct) begin
                @(posedge clk);
                #1;
            end
            guard = 0;
            while (!(sReady[0] && sReady[1]) && guard < 1000) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 1000) begin
                checks++;
                errors++;
                $display("[TB] FAIL load_ready_timeout word %0d: got s_ready %b, expected 11", i, sReady);
            end
            sValid = 1'b1;
            sData  = w[i];
            @(posedge clk);
            #1;
        end
        sValid = 1'b0;
    endtask

    task automatic waitDone(input int target);
        int guard = 0;
        while (!(doneCnt[0] >= target && doneCnt[1] >= target) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got %0d/%0d, expected %0d", doneCnt[0], doneCnt[1], target);
        end
    endtask

    task automatic waitValid(input int g);
        int guard = 0;
        while (!mValid[g] && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL valid_timeout dut%0d: got m_valid 0, expected 1", g);
        end
    endtask

    initial begin
        logic signed [7:0] w[12];
        int guard;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput("rst_s_ready", g, int'(sReady[g]), 1);
            checkOutput("rst_m_valid", g, int'(mValid[g]), 0);
            checkOutput("rst_mac_en", g, int'(macEn[g]), 0);
            checkOutput("rst_mac_clear", g, int'(macClear[g]), 0);
            checkOutput("rst_done", g, int'(done[g]), 0);
            checkOutput("rst_addr_a", g, int'(addrA[g]), 0);
            checkOutput("rst_addr_x", g, int'(addrX[g]), 0);
            checkOutput("rst_out_row", g, int'(outRow[g]), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) w[i] = 8'(i + 1);
        w[9]  = 8'sd1;
        w[10] = 8'sd2;
        w[11] = 8'sd3;
        applyStimulus(w, 0, 14, 32, 50);
        waitDone(1);

        applyStimulus(w, 50, 14, 32, 50);
        waitDone(2);

        // Downstream stall on row 0.
        mReady = 1'b0;
        applyStimulus(w, 0, 14, 32, 50);
        waitValid(0);
        waitValid(1);
        repeat (20) @(posedge clk);
        #1;
        mReady = 1'b1;
        waitDone(3);

        // Abort during row 1 of the MEM_LAT=1 controller.
        applyStimulus(w, 0, 14, 32, 50);
        waitValid(0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput("abort_s_ready", g, int'(sReady[g]), 1);
            checkOutput("abort_m_valid", g, int'(mValid[g]), 0);
            checkOutput("abort_mac_en", g, int'(macEn[g]), 0);
        end

        for (int i = 0; i < 9; i++) w[i] = 8'sd2;
        w[9]  = 8'sd1;
        w[10] = 8'sd1;
        w[11] = 8'sd1;
        applyStimulus(w, 0, 6, 6, 6);
        waitDone(4);

        for (int i = 0; i < 9; i++) w[i] = (i % 4 == 0) ? 8'sd1 : 8'sd0;
        w[9]  = 8'sd7;
        w[10] = -8'sd3;
        w[11] = 8'sd5;
        applyStimulus(w, 0, 7, -3, 5);
        waitDone(5);

        guard = 0;
        repeat (5) @(negedge clk);
        for (int g = 0; g < 2; g++) checkOutput("done_count", g, doneCnt[g], 5);
        checkOutput("queue_empty", 0, expQ0.size(), 0);
        checkOutput("queue_empty", 1, expQ1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
